systolic_matmul_test: RTL and testbench



---
 rtl/systolic_matmul_test.sv | 159 +++++++++++++++
 tb/tb_systolic_matmul_test.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul_test.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_matmul_test
//  Function : 3x3 output-stationary systolic matrix multiplier. It computes
//             C = A x B from operands held on chip and streams C out serially.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_matmul_test #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int N      = 3,
    parameter int K      = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    output logic [OUT_W-1:0] OUT,
    output logic             OUT_VALID,
    output logic             DONE
);

    localparam int STEPS = K + 2 * (N - 1);
    localparam int WORDS = 2 * N * K;
    localparam int AW    = $clog2(WORDS);
    localparam int SW    = $clog2(STEPS + 1);
    localparam int IW    = $clog2(N * N + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem      [WORDS];
    logic [SW-1:0]       r_step;
    logic [IW-1:0]       r_idx;
    logic [DATA_W-1:0]   w_feed_a   [N];
    logic [DATA_W-1:0]   w_feed_b   [N];
    logic [DATA_W-1:0]   w_a_east   [N*N];
    logic [DATA_W-1:0]   w_b_south  [N*N];
    logic [OUT_W-1:0]    w_acc      [N*N];
    logic                w_compute;

    assign w_compute = ENABLE && (r_state == ST_COMPUTE);

    // Edge feeds: row i of A and column i of B enter i steps late, zero outside the window.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_feed_a[i] = '0;
            w_feed_b[i] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (int'(r_step) >= i && int'(r_step) < i + K) begin
                w_feed_a[i] = r_mem[AW'(K * i + int'(r_step) - i)];
                w_feed_b[i] = r_mem[AW'(N * K + N * (int'(r_step) - i) + i)];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            localparam int P = i * N + j;
            logic [DATA_W-1:0]   w_ain;
            logic [DATA_W-1:0]   w_bin;
            logic [DATA_W-1:0]   r_a;
            logic [DATA_W-1:0]   r_b;
            logic [2*DATA_W-1:0] w_prod;
            logic [OUT_W-1:0]    r_acc;

            if (j == 0) begin : g_a_edge
                assign w_ain = w_feed_a[i];
            end else begin : g_a_pass
                assign w_ain = w_a_east[P-1];
            end

            if (i == 0) begin : g_b_edge
                assign w_bin = w_feed_b[j];
            end else begin : g_b_pass
                assign w_bin = w_b_south[P-N];
            end

            assign w_prod = w_ain * w_bin;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_acc <= '0;
                end else if (w_compute) begin
                    r_a   <= w_ain;
                    r_b   <= w_bin;
                    r_acc <= r_acc + OUT_W'(w_prod);
                end
            end

            assign w_a_east[P]  = r_a;
            assign w_b_south[P] = r_b;
            assign w_acc[P]     = r_acc;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ENABLE) begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_COMPUTE;
                ST_COMPUTE: if (r_step == SW'(STEPS - 1)) w_state_nxt = ST_OUTPUT;
                ST_OUTPUT:  if (r_idx == IW'(N * N - 1)) w_state_nxt = ST_DONE;
                default:    w_state_nxt = ST_DONE;
            endcase
        end
    end

    // Operand memory is (re)initialised on every reset edge and read-only afterwards.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int w = 0; w < WORDS; w++) begin
                r_mem[w] <= DATA_W'(w + 1);
            end
            r_step    <= '0;
            r_idx     <= '0;
            OUT       <= '0;
            OUT_VALID <= 1'b0;
            DONE      <= 1'b0;
        end else if (ENABLE) begin
            case (r_state)
                ST_IDLE: begin
                    r_step <= '0;
                end
                ST_COMPUTE: begin
                    r_step <= r_step + 1'b1;
                end
                ST_OUTPUT: begin
                    OUT       <= w_acc[r_idx];
                    OUT_VALID <= 1'b1;
                    r_idx     <= r_idx + 1'b1;
                end
                default: begin
                    OUT       <= '0;
                    OUT_VALID <= 1'b0;
                    DONE      <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_matmul_test.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_matmul_test
//  Function : Directed self-checking bench for systolic_matmul_test.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_matmul_test;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic [15:0] OUT;
    logic        OUT_VALID;
    logic        DONE;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] sb [$];
    logic [15:0] last_exp;
    int          valid_seen;
    int          en_edges;
    int          first_valid;
    int          done_edge;
    int          edges;
    int          bad;
    int          vrun;

    systolic_matmul_test dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference product from the documented memory image: mem[w] = w+1.
    task automatic push_run();
        int s;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                s = 0;
                for (int k = 0; k < 6; k++) s += (6 * i + k + 1) * (18 + 3 * k + j + 1);
                sb.push_back(16'(s));
            end
        end
    endtask

    task automatic restart_counters();
        valid_seen  = 0;
        en_edges    = 0;
        first_valid = -1;
        done_edge   = -1;
    endtask

    task automatic tick();
        logic en_at_edge;
        en_at_edge = (ENABLE === 1'b1);
        @(posedge CLK);
        #1;
        if (en_at_edge && RESET === 1'b0) begin
            en_edges++;
            if (OUT_VALID === 1'b1) begin
                valid_seen++;
                if (first_valid < 0) first_valid = en_edges;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'd0, OUT_VALID}, 32'd0);
                end else begin
                    last_exp = sb.pop_front();
                    chk("out_value", {16'd0, OUT}, {16'd0, last_exp});
                end
            end
            if (DONE === 1'b1 && done_edge < 0) done_edge = en_edges;
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_out"},   {16'd0, OUT},       32'd0);
        chk({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd0);
        chk({tag, "_done"},  {31'd0, DONE},      32'd0);
    endtask

    task automatic run_until_done(input int limit);
        for (int n = 0; n < limit; n++) begin
            if (DONE === 1'b1) break;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with ENABLE unknown: outputs clear and stay cleared.
        RESET  = 1'b1;
        ENABLE = 1'bx;
        tick();
        check_cleared("reset_c1");
        tick();
        check_cleared("reset_c2");

        // Released but not enabled: nothing advances.
        RESET  = 1'b0;
        ENABLE = 1'b0;
        tick();
        tick();
        check_cleared("frozen_idle");

        // Full uninterrupted run.
        restart_counters();
        push_run();
        ENABLE = 1'b1;
        edges  = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            edges++;
            if (OUT_VALID === 1'b1) break;
        end
        chk("latency_edges", edges, 32'd12);
        vrun = 1;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (OUT_VALID === 1'b1) vrun++;
        end
        chk("valid_run_len", vrun, 32'd9);
        tick();
        chk("done_set",       {31'd0, DONE},      32'd1);
        chk("done_out",       {16'd0, OUT},       32'd0);
        chk("done_valid",     {31'd0, OUT_VALID}, 32'd0);
        chk("run1_sb_empty",  sb.size(),          32'd0);
        chk("run1_done_edge", done_edge,          32'd21);
        bad = 0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (DONE !== 1'b1 || OUT !== 16'd0 || OUT_VALID !== 1'b0) bad++;
        end
        chk("post_done_stable", bad, 32'd0);

        // Run with stalls in COMPUTE and OUTPUT.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        restart_counters();
        push_run();
        ENABLE = 1'b1;
        for (int n = 0; n < 6; n++) tick();
        ENABLE = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        chk("stall_cmp_valid", {31'd0, OUT_VALID}, 32'd0);
        ENABLE = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (valid_seen >= 4) break;
            tick();
        end
        ENABLE = 1'b0;
        bad = 0;
        for (int n = 0; n < 2; n++) begin
            tick();
            if (OUT !== last_exp || OUT_VALID !== 1'b1) bad++;
        end
        chk("stall_out_hold", bad, 32'd0);
        chk("stall_hold_val", {16'd0, OUT}, 32'd1563);
        ENABLE = 1'b1;
        run_until_done(40);
        chk("stall_first_valid", first_valid, 32'd12);
        chk("stall_valid_cnt",   valid_seen,  32'd9);
        chk("stall_done_edge",   done_edge,   32'd21);
        chk("stall_sb_empty",    sb.size(),   32'd0);

        // Reset mid-OUTPUT after C11, then a clean rerun.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        restart_counters();
        push_run();
        ENABLE = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (valid_seen >= 5) break;
            tick();
        end
        RESET = 1'b1;
        tick();
        check_cleared("midrun_reset");
        RESET = 1'b0;
        restart_counters();
        push_run();
        run_until_done(40);
        chk("rerun_first_valid", first_valid, 32'd12);
        chk("rerun_valid_cnt",   valid_seen,  32'd9);
        chk("rerun_sb_empty",    sb.size(),   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
